// File: rtl/me_ref_row_loader_pkg.sv
// Shared motion-estimation constants for the reference-row loader and its output register.
// Rows are 23 pixels built from three 8-pixel memory beats.
package me_ref_row_loader_pkg;

    localparam int PIX_W         = 8;
    localparam int ROW_PIX       = 23;
    localparam int ROW_W         = ROW_PIX * PIX_W;
    localparam int BEAT_PIX      = 8;
    localparam int BEAT_W        = BEAT_PIX * PIX_W;
    localparam int BEATS_PER_ROW = 3;
    localparam int FIFO_ROW_W    = 128;
    localparam int STAGE_W       = 2 * BEAT_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    // The last byte of the third beat is surplus: 16 staged pixels plus 7 more make a row.
    function automatic logic [ROW_W-1:0] pack_row(input logic [STAGE_W-1:0] staging,
                                                  input logic [BEAT_W-1:0]  beat);
        return {staging, beat[BEAT_W-1:PIX_W]};
    endfunction

endpackage

// File: rtl/me_ref_row_loader_row_out_reg.sv
// Single-entry valid/ready output register feeding the reference-row FIFO chain.
// A new row loading on the same edge as a consume takes priority and keeps valid high.
module me_row_out_reg
    import me_ref_row_loader_pkg::*;
#(
    parameter int W = ROW_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         take_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign take_o  = valid_q && ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (take_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/me_ref_row_loader.sv
// Packs 64-bit memory beats into 184-bit search-window rows and counts consumed rows,
// pulsing done_o once ROWS rows have been handed to the FIFO chain.
module me_ref_row_loader
    import me_ref_row_loader_pkg::*;
#(
    parameter int ROWS = 23
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [BEAT_W-1:0] mem_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    output logic [ROW_W-1:0]  data_out,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0] ROWS_C   = 8'(ROWS);

    state_e             state_q;
    logic [1:0]         beat_cnt_q;
    logic [7:0]         row_cnt_q;
    logic [7:0]         asm_cnt_q;
    logic [STAGE_W-1:0] staging_q;
    logic               done_q;

    logic last_beat;
    logic all_built;
    logic beat_take;
    logic row_load;
    logic row_take;

    assign last_beat = (beat_cnt_q == 2'd2);
    // Once every row of the window is assembled, stop pulling beats even if rows are still draining.
    assign all_built = (asm_cnt_q == ROWS_C);

    assign mem_ready_o = (state_q == FILL) && !all_built
                         && (!last_beat || !out_valid_o || out_ready_i);
    assign beat_take   = mem_valid_i && mem_ready_o;
    assign row_load    = beat_take && last_beat;

    assign busy_o = (state_q == FILL);
    assign done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= 2'd0;
            row_cnt_q  <= 8'd0;
            asm_cnt_q  <= 8'd0;
            staging_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= FILL;
                        beat_cnt_q <= 2'd0;
                        row_cnt_q  <= 8'd0;
                        asm_cnt_q  <= 8'd0;
                    end
                end
                FILL: begin
                    if (beat_take) begin
                        case (beat_cnt_q)
                            2'd0: begin
                                staging_q[STAGE_W-1 -: BEAT_W] <= mem_data_i;
                                beat_cnt_q <= 2'd1;
                            end
                            2'd1: begin
                                staging_q[BEAT_W-1:0] <= mem_data_i;
                                beat_cnt_q <= 2'd2;
                            end
                            default: begin
                                beat_cnt_q <= 2'd0;
                                asm_cnt_q  <= asm_cnt_q + 8'd1;
                            end
                        endcase
                    end
                    if (row_take) begin
                        row_cnt_q <= row_cnt_q + 8'd1;
                        if (row_cnt_q == LAST_ROW) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    me_row_out_reg #(
        .W (ROW_W)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (row_load),
        .load_data_i (pack_row(staging_q, mem_data_i)),
        .ready_i     (out_ready_i),
        .valid_o     (out_valid_o),
        .data_o      (data_out),
        .take_o      (row_take)
    );

endmodule

// File: tb/tb_me_ref_row_loader.sv
// Scoreboard bench for me_ref_row_loader: expected rows are queued as beats are driven
// and compared as the consumer takes them; a second ROWS=1 instance covers the single-row window.
module tb_me_ref_row_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         startI;
    logic [63:0]  memData;
    logic         memValid;
    logic         memReady;
    logic [183:0] dataOut;
    logic         outValid;
    logic         outReady;
    logic         busy;
    logic         done;

    logic         s1Start;
    logic [63:0]  s1Data;
    logic         s1Valid;
    logic         s1MemReady;
    logic [183:0] s1Out;
    logic         s1OutValid;
    logic         s1Ready;
    logic         s1Busy;
    logic         s1Done;

    int           checks = 0;
    int           failures = 0;
    int           doneCount = 0;
    int           rowsSeen = 0;
    int           cycleCnt = 0;
    logic [183:0] sb[$];
    int           hsCycles[$];

    always #5 clk = ~clk;

    me_ref_row_loader #(.ROWS(23)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (startI),
        .mem_data_i  (memData),
        .mem_valid_i (memValid),
        .mem_ready_o (memReady),
        .data_out    (dataOut),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .busy_o      (busy),
        .done_o      (done)
    );

    me_ref_row_loader #(.ROWS(1)) dutOne (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (s1Start),
        .mem_data_i  (s1Data),
        .mem_valid_i (s1Valid),
        .mem_ready_o (s1MemReady),
        .data_out    (s1Out),
        .out_valid_o (s1OutValid),
        .out_ready_i (s1Ready),
        .busy_o      (s1Busy),
        .done_o      (s1Done)
    );

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [183:0] obs, input logic [183:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream byte i of a window is seed+i; beat b carries stream bytes 8b..8b+7.
    function automatic logic [63:0] beatOf(input logic [7:0] seed, input int b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[63-8*j -: 8] = seed + 8'(8*b + j);
        return r;
    endfunction

    function automatic logic [183:0] expRow(input logic [7:0] seed, input int n);
        logic [183:0] r;
        r = '0;
        for (int k = 0; k < 23; k++) r[183-8*k -: 8] = seed + 8'(24*n + k);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (outValid && outReady) begin
                rowsSeen++;
                hsCycles.push_back(cycleCnt);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL row_unexpected observed=%0h expected=none", dataOut);
                end else begin
                    checkOutput("row", dataOut, sb.pop_front());
                end
            end
            if (done) doneCount++;
        end
    end

    task automatic applyStimulus(input logic [63:0] d, input int validPct, output int waited);
        int  idle;
        int  w;
        bit  acc;
        idle = 0;
        while (validPct < 100 && $urandom_range(0, 99) >= validPct && idle < 50) begin
            memValid = 1'b0;
            @(posedge clk); #1;
            idle++;
        end
        memValid = 1'b1;
        memData  = d;
        acc = 1'b0;
        w = 0;
        while (!acc && w < 100) begin
            @(negedge clk);
            acc = memReady;
            @(posedge clk); #1;
            w++;
        end
        memValid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $error("[TB] FAIL beat_timeout observed=no_accept expected=accept");
        end
        waited = w;
    endtask

    task automatic pulseStart();
        startI = 1'b1;
        @(posedge clk); #1;
        startI = 1'b0;
    endtask

    task automatic driveBeats(input logic [7:0] seed, input int from, input int validPct, input bit startMid);
        int w;
        for (int b = from; b < 69; b++) begin
            if (b % 3 == 2) sb.push_back(expRow(seed, b / 3));
            if (startMid && b == 10) startI = 1'b1;
            applyStimulus(beatOf(seed, b), validPct, w);
            if (startMid && b == 11) startI = 1'b0;
        end
    endtask

    task automatic finishWindow(input int d0, input int r0, input bit checkGap);
        int n;
        n = 0;
        while (doneCount == d0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("done_count", 184'(doneCount - d0), 184'(1));
        checkOutput("rows_consumed", 184'(rowsSeen - r0), 184'(23));
        checkOutput("busy_after", 184'(busy), 184'(0));
        checkOutput("mem_ready_after", 184'(memReady), 184'(0));
        checkOutput("sb_drained", 184'(sb.size()), 184'(0));
        if (checkGap)
            for (int i = 1; i < hsCycles.size(); i++)
                checkOutput("row_gap", 184'(hsCycles[i] - hsCycles[i-1]), 184'(3));
    endtask

    initial begin
        int d0;
        int r0;
        int w;
        startI = 1'b0; memData = '0; memValid = 1'b0; outReady = 1'b1;
        s1Start = 1'b0; s1Data = '0; s1Valid = 1'b0; s1Ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_data_out", dataOut, '0);
        checkOutput("rst_out_valid", 184'(outValid), 184'(0));
        checkOutput("rst_mem_ready", 184'(memReady), 184'(0));
        checkOutput("rst_busy", 184'(busy), 184'(0));
        checkOutput("rst_done", 184'(done), 184'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Beats offered while idle must stay pending upstream.
        memValid = 1'b1;
        memData  = 64'hDEADBEEFCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_mem_ready", 184'(memReady), 184'(0));
            checkOutput("idle_out_valid", 184'(outValid), 184'(0));
            @(posedge clk); #1;
        end
        memValid = 1'b0;

        // Single-row window on the ROWS=1 instance.
        s1Start = 1'b1;
        @(posedge clk); #1;
        s1Start = 1'b0;
        checkOutput("one_busy", 184'(s1Busy), 184'(1));
        s1Valid = 1'b1;
        s1Data  = 64'h0001020304050607;
        checkOutput("one_mem_ready_b0", 184'(s1MemReady), 184'(1));
        @(posedge clk); #1;
        s1Data = 64'h08090A0B0C0D0E0F;
        checkOutput("one_mem_ready_b1", 184'(s1MemReady), 184'(1));
        @(posedge clk); #1;
        s1Data = 64'h10111213141516FF;
        checkOutput("one_mem_ready_b2", 184'(s1MemReady), 184'(1));
        checkOutput("one_valid_before", 184'(s1OutValid), 184'(0));
        @(posedge clk); #1;
        s1Valid = 1'b0;
        checkOutput("one_valid_after", 184'(s1OutValid), 184'(1));
        checkOutput("one_row", s1Out, 184'h000102030405060708090a0b0c0d0e0f10111213141516);
        checkOutput("one_mem_ready_end", 184'(s1MemReady), 184'(0));
        checkOutput("one_done_early", 184'(s1Done), 184'(0));
        @(posedge clk); #1;
        checkOutput("one_done", 184'(s1Done), 184'(1));
        checkOutput("one_busy_end", 184'(s1Busy), 184'(0));
        checkOutput("one_valid_end", 184'(s1OutValid), 184'(0));
        @(posedge clk); #1;
        checkOutput("one_done_pulse", 184'(s1Done), 184'(0));

        // Full window, continuous valid and ready.
        d0 = doneCount; r0 = rowsSeen;
        pulseStart();
        hsCycles.delete();
        driveBeats(8'h00, 0, 100, 1'b0);
        finishWindow(d0, r0, 1'b1);

        // Sparse input with a start pulse that must be ignored mid-window.
        d0 = doneCount; r0 = rowsSeen;
        pulseStart();
        driveBeats(8'h40, 0, 30, 1'b1);
        finishWindow(d0, r0, 1'b0);

        // Output stall while row 1 stages behind row 0.
        d0 = doneCount; r0 = rowsSeen;
        outReady = 1'b0;
        pulseStart();
        sb.push_back(expRow(8'h80, 0));
        for (int b = 0; b < 3; b++) applyStimulus(beatOf(8'h80, b), 100, w);
        checkOutput("stall_row0_valid", 184'(outValid), 184'(1));
        sb.push_back(expRow(8'h80, 1));
        applyStimulus(beatOf(8'h80, 3), 100, w);
        checkOutput("stall_b0_wait", 184'(w), 184'(1));
        applyStimulus(beatOf(8'h80, 4), 100, w);
        checkOutput("stall_b1_wait", 184'(w), 184'(1));
        memValid = 1'b1;
        memData  = beatOf(8'h80, 5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("stall_mem_ready", 184'(memReady), 184'(0));
            checkOutput("stall_data", dataOut, expRow(8'h80, 0));
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_ready", 184'(memReady), 184'(1));
        @(posedge clk); #1;
        memValid = 1'b0;
        checkOutput("stall_row1_valid", 184'(outValid), 184'(1));
        checkOutput("stall_row1_data", dataOut, expRow(8'h80, 1));
        driveBeats(8'h80, 6, 100, 1'b0);
        finishWindow(d0, r0, 1'b0);

        // Asynchronous reset mid-window, then a clean window.
        d0 = doneCount;
        outReady = 1'b0;
        pulseStart();
        sb.push_back(expRow(8'hC0, 0));
        for (int b = 0; b < 4; b++) applyStimulus(beatOf(8'hC0, b), 100, w);
        checkOutput("abort_pre_data", dataOut, expRow(8'hC0, 0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_data_out", dataOut, '0);
        checkOutput("abort_out_valid", 184'(outValid), 184'(0));
        checkOutput("abort_mem_ready", 184'(memReady), 184'(0));
        checkOutput("abort_busy", 184'(busy), 184'(0));
        checkOutput("abort_done", 184'(done), 184'(0));
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_no_done", 184'(doneCount - d0), 184'(0));
        d0 = doneCount; r0 = rowsSeen;
        pulseStart();
        driveBeats(8'hE0, 0, 100, 1'b0);
        finishWindow(d0, r0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
